// File: rtl/decoder_backward_update.sv
// Backward pass for the VAE decoder output layer: per-element error, SGD update of
// wk1/wk2/b3k and accumulation of the latent gradient, one element every two cycles.
module decoder_backward_update #(
  parameter int LR_SHIFT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [143:0] out_vec,
  input  logic [143:0] x_vec,
  input  logic [15:0]  z1,
  input  logic [15:0]  z2,
  input  logic [287:0] w_vec,
  input  logic [143:0] b_vec,
  output logic [287:0] w_new_vec,
  output logic [143:0] b_new_vec,
  output logic [15:0]  dz1,
  output logic [15:0]  dz2,
  output logic         busy,
  output logic         done
);

  localparam int DATA_W = 16;
  localparam int PROD_W = 32;
  localparam int ACC_W  = 36;
  localparam int N_ELEM = 9;
  localparam logic signed [ACC_W-1:0] SAT_MAX = 36'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -36'sd32768;

  typedef enum logic [1:0] {IDLE, ERR, GRAD, FIN} state_t;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)
      sat16 = 16'sh7FFF;
    else if (v < SAT_MIN)
      sat16 = 16'sh8000;
    else
      sat16 = v[DATA_W-1:0];
  endfunction

  state_t state_q, state_d;
  logic   ld, e_en, upd, fin;

  logic [3:0]               k_q;
  logic signed [ACC_W-1:0]  acc1_q, acc2_q;

  // Working copies of everything latched at start
  logic signed [DATA_W-1:0] out_w [N_ELEM];
  logic signed [DATA_W-1:0] x_w   [N_ELEM];
  logic signed [DATA_W-1:0] w1_w  [N_ELEM];
  logic signed [DATA_W-1:0] w2_w  [N_ELEM];
  logic signed [DATA_W-1:0] b_w   [N_ELEM];
  logic signed [DATA_W-1:0] z1_w, z2_w;

  logic signed [DATA_W-1:0] e_p0;

  logic signed [DATA_W-1:0] o_sel, x_sel, w1_sel, w2_sel, b_sel;
  logic signed [DATA_W:0]   diff;
  logic signed [DATA_W-1:0] e_d;
  logic signed [PROD_W-1:0] p1, p2, q1, q2, d1, d2;
  logic signed [DATA_W-1:0] bd;
  logic signed [DATA_W-1:0] w1_n, w2_n, b_n;
  logic signed [ACC_W-1:0]  acc1_n, acc2_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    e_en    = 1'b0;
    upd     = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        ld      = 1'b1;
        state_d = ERR;
      end
      ERR: begin
        e_en    = 1'b1;
        state_d = GRAD;
      end
      GRAD: begin
        upd     = 1'b1;
        state_d = (k_q == 4'd8) ? FIN : ERR;
      end
      FIN: begin
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: element error, 17-bit difference saturated back to Q8.8
  assign o_sel  = out_w[k_q];
  assign x_sel  = x_w[k_q];
  assign w1_sel = w1_w[k_q];
  assign w2_sel = w2_w[k_q];
  assign b_sel  = b_w[k_q];
  assign diff   = 17'(o_sel) - 17'(x_sel);
  assign e_d    = sat16(36'(diff));

  // Stage p1: shared four-multiplier gradient and SGD update using the registered error
  assign p1     = 32'(e_p0) * 32'(z1_w);
  assign p2     = 32'(e_p0) * 32'(z2_w);
  assign q1     = 32'(e_p0) * 32'(w1_sel);
  assign q2     = 32'(e_p0) * 32'(w2_sel);
  assign d1     = (p1 >>> 8) >>> LR_SHIFT;
  assign d2     = (p2 >>> 8) >>> LR_SHIFT;
  assign bd     = e_p0 >>> LR_SHIFT;
  assign w1_n   = sat16(36'(w1_sel) - 36'(d1));
  assign w2_n   = sat16(36'(w2_sel) - 36'(d2));
  assign b_n    = sat16(36'(b_sel) - 36'(bd));
  assign acc1_n = acc1_q + 36'(q1);
  assign acc2_n = acc2_q + 36'(q2);

  always_ff @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < N_ELEM; i++) begin
        out_w[i] <= out_vec[16*i +: 16];
        x_w[i]   <= x_vec[16*i +: 16];
        w1_w[i]  <= w_vec[32*i +: 16];
        w2_w[i]  <= w_vec[32*i+16 +: 16];
        b_w[i]   <= b_vec[16*i +: 16];
      end
      z1_w <= z1;
      z2_w <= z2;
    end
    if (e_en)
      e_p0 <= e_d;
    if (upd) begin
      w1_w[k_q] <= w1_n;
      w2_w[k_q] <= w2_n;
      b_w[k_q]  <= b_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q       <= '0;
      acc1_q    <= '0;
      acc2_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_new_vec <= '0;
      b_new_vec <= '0;
      dz1       <= '0;
      dz2       <= '0;
    end else begin
      done <= fin;
      if (ld) begin
        k_q    <= '0;
        acc1_q <= '0;
        acc2_q <= '0;
        busy   <= 1'b1;
      end
      if (upd) begin
        acc1_q <= acc1_n;
        acc2_q <= acc2_n;
        if (k_q != 4'd8)
          k_q <= k_q + 4'd1;
      end
      // Results become visible only here, so a run in progress never shows partial values
      if (fin) begin
        busy <= 1'b0;
        for (int i = 0; i < N_ELEM; i++) begin
          w_new_vec[32*i +: 16]    <= w1_w[i];
          w_new_vec[32*i+16 +: 16] <= w2_w[i];
          b_new_vec[16*i +: 16]    <= b_w[i];
        end
        dz1 <= sat16(acc1_q >>> 8);
        dz2 <= sat16(acc2_q >>> 8);
      end
    end
  end

endmodule

// File: tb/tb_decoder_backward_update.sv
// Directed bench for decoder_backward_update: hand-computed expectations for zero error,
// single error, saturation, truncation, handshake, back-to-back and mid-run reset.
module tb_decoder_backward_update;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [143:0] out_vec, x_vec, b_vec;
  logic [287:0] w_vec;
  logic [15:0]  z1, z2;
  logic [287:0] w_new_vec;
  logic [143:0] b_new_vec;
  logic [15:0]  dz1, dz2;
  logic         busy, done;

  decoder_backward_update #(.LR_SHIFT(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .out_vec(out_vec), .x_vec(x_vec), .z1(z1), .z2(z2),
    .w_vec(w_vec), .b_vec(b_vec),
    .w_new_vec(w_new_vec), .b_new_vec(b_new_vec),
    .dz1(dz1), .dz2(dz2), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int lat, nd;
  logic held;

  logic [15:0] o [9], x [9], w1 [9], w2 [9], b [9];
  logic [15:0] ew1 [9], ew2 [9], eb [9];
  logic [15:0] edz1, edz2;

  task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [287:0] pack_ew();
    logic [287:0] r;
    for (int i = 0; i < 9; i++) begin
      r[32*i +: 16]    = ew1[i];
      r[32*i+16 +: 16] = ew2[i];
    end
    return r;
  endfunction

  function automatic logic [143:0] pack_eb();
    logic [143:0] r;
    for (int i = 0; i < 9; i++) r[16*i +: 16] = eb[i];
    return r;
  endfunction

  task automatic apply_vec();
    for (int i = 0; i < 9; i++) begin
      out_vec[16*i +: 16]  = o[i];
      x_vec[16*i +: 16]    = x[i];
      w_vec[32*i +: 16]    = w1[i];
      w_vec[32*i+16 +: 16] = w2[i];
      b_vec[16*i +: 16]    = b[i];
    end
  endtask

  task automatic set_default();
    for (int i = 0; i < 9; i++) begin
      o[i]  = 16'h0100;
      x[i]  = 16'h0100;
      w1[i] = 16'h0010 + 16'(i * 3);
      w2[i] = 16'hFF00 + 16'(i);
      b[i]  = 16'h0200 + 16'(i * 17);
    end
  endtask

  task automatic set_exp();
    for (int i = 0; i < 9; i++) begin
      ew1[i] = w1[i];
      ew2[i] = w2[i];
      eb[i]  = b[i];
    end
    edz1 = 16'h0000;
    edz2 = 16'h0000;
  endtask

  task automatic set_single();
    set_default();
    z1 = 16'h0100; z2 = 16'h0000;
    o[0] = 16'h0180; x[0] = 16'h0100;
    w1[0] = 16'h0024; w2[0] = 16'h0044; b[0] = 16'h04F0;
    set_exp();
    ew1[0] = 16'h001C; eb[0] = 16'h04E8;
    edz1 = 16'h0012; edz2 = 16'h0022;
  endtask

  task automatic set_sat();
    set_default();
    z1 = 16'h7FFF; z2 = 16'h0000;
    o[0] = 16'h8000; x[0] = 16'h7FFF; w1[0] = 16'h7FF0; w2[0] = 16'h0000; b[0] = 16'h7FF8;
    o[1] = 16'h8000; x[1] = 16'h7FFF; w1[1] = 16'h0000; w2[1] = 16'h0000; b[1] = 16'h7000;
    set_exp();
    ew1[0] = 16'h7FFF; eb[0] = 16'h7FFF;
    ew1[1] = 16'h7FFF; eb[1] = 16'h7800;
    edz1 = 16'h8000; edz2 = 16'h0000;
  endtask

  task automatic set_neg();
    set_default();
    z1 = 16'h0100; z2 = 16'h0080;
    o[4] = 16'h0000; x[4] = 16'h0200; w1[4] = 16'h0100; w2[4] = 16'h0040; b[4] = 16'h0010;
    o[8] = 16'h0000; x[8] = 16'h0001; w1[8] = 16'h0010; w2[8] = 16'h0020; b[8] = 16'h0000;
    set_exp();
    ew1[4] = 16'h0120; ew2[4] = 16'h0050; eb[4] = 16'h0030;
    ew1[8] = 16'h0011; ew2[8] = 16'h0021; eb[8] = 16'h0001;
    edz1 = 16'hFDFF; edz2 = 16'hFF7F;
  endtask

  task automatic check_all(input string name);
    chk({name, "_w_new"}, w_new_vec, pack_ew());
    chk({name, "_b_new"}, 288'(b_new_vec), 288'(pack_eb()));
    chk({name, "_dz1"}, 288'(dz1), 288'(edz1));
    chk({name, "_dz2"}, 288'(dz2), 288'(edz2));
  endtask

  // Called just after an edge; start is sampled at the next edge (T0).
  task automatic run(input int poke, output int lat_o, output logic held_o);
    logic [287:0] w0;
    logic [143:0] b0;
    apply_vec();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w0 = w_new_vec;
    b0 = b_new_vec;
    held_o = 1'b1;
    chk("busy_at_t0", 288'(busy), 288'(1));
    chk("done_at_t0", 288'(done), 288'(0));
    lat_o = 0;
    while (done !== 1'b1 && lat_o < 40) begin
      start = (lat_o + 1 == poke);
      @(posedge clk); #1;
      lat_o++;
      if (done !== 1'b1 && (w_new_vec !== w0 || b_new_vec !== b0)) held_o = 1'b0;
    end
    start = 1'b0;
    chk("busy_at_done", 288'(busy), 288'(0));
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done === 1'b1) cnt++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    out_vec = '0; x_vec = '0; w_vec = '0; b_vec = '0; z1 = '0; z2 = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_w_new", w_new_vec, 288'(0));
    chk("rst_b_new", 288'(b_new_vec), 288'(0));
    chk("rst_dz1", 288'(dz1), 288'(0));
    chk("rst_dz2", 288'(dz2), 288'(0));
    chk("rst_busy", 288'(busy), 288'(0));
    chk("rst_done", 288'(done), 288'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // zero error: everything passes through unchanged
    set_default(); z1 = 16'h0123; z2 = 16'hFF80; set_exp();
    run(0, lat, held);
    chk("zero_latency", 288'(lat), 288'(19));
    chk("zero_hold", 288'(held), 288'(1));
    check_all("zero");
    @(posedge clk); #1;
    chk("zero_done_one_cycle", 288'(done), 288'(0));

    // single error with a stray start at T0+5
    set_single();
    run(5, lat, held);
    chk("single_latency", 288'(lat), 288'(19));
    chk("single_hold", 288'(held), 288'(1));
    check_all("single");
    count_done(25, nd);
    chk("single_no_second_done", 288'(nd), 288'(0));
    check_all("single_after");

    // saturation of error, weights, bias and dz
    set_sat();
    run(0, lat, held);
    chk("sat_latency", 288'(lat), 288'(19));
    check_all("sat");

    // negative error and truncation toward minus infinity
    set_neg();
    run(0, lat, held);
    chk("neg_latency", 288'(lat), 288'(19));
    check_all("neg");

    // back-to-back: start again during the done cycle
    set_single();
    run(0, lat, held);
    chk("b2b_latency", 288'(lat), 288'(19));
    chk("b2b_first_holds", 288'(held), 288'(1));
    check_all("b2b");

    // reset mid-run at T0+7
    set_neg();
    apply_vec();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_w_new", w_new_vec, 288'(0));
    chk("midrst_b_new", 288'(b_new_vec), 288'(0));
    chk("midrst_dz1", 288'(dz1), 288'(0));
    chk("midrst_dz2", 288'(dz2), 288'(0));
    chk("midrst_busy", 288'(busy), 288'(0));
    chk("midrst_done", 288'(done), 288'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    count_done(25, nd);
    chk("midrst_no_done", 288'(nd), 288'(0));
    chk("midrst_w_still_zero", w_new_vec, 288'(0));
    run(0, lat, held);
    chk("post_rst_latency", 288'(lat), 288'(19));
    check_all("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/decoder_backward_update.md
# decoder_backward_update

Sequential backward-pass unit for the VAE decoder output layer: the gradient-side counterpart of the forward decoder (latent z1/z2 → nine Q8.8 outputs through weights wk1/wk2 and biases b3k). It takes one forward result, the nine target pixels, the latent pair, and the current decoder weights and biases. It produces SGD-updated weights and biases, plus the error gradient back-propagated to the latent (dz1, dz2) for the encoder update. One element is processed per two cycles using a single shared four-multiplier datapath.

## Interface
- LR_SHIFT, 4, learning rate as an arithmetic right shift (lr = 2^-LR_SHIFT), legal range 0..15
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request; sampled only in IDLE
- out_vec  in  144  forward outputs out1..out9, Q8.8 signed; element k (0-based, out(k+1)) at [16k+15:16k]
- x_vec  in  144  targets x1..x9, same packing
- z1, z2  in  16 each  latent sample, Q8.8 signed
- w_vec  in  288  weights; wk1 at [32k+15:32k], wk2 at [32k+31:32k+16] for element k
- b_vec  in  144  biases b31..b39, same packing as out_vec
- w_new_vec  out  288  updated weights, same packing as w_vec
- b_new_vec  out  144  updated biases
- dz1, dz2  out  16 each  latent gradient, Q8.8 signed
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the outputs update

## Operation
- States: IDLE, ERR, GRAD, FIN.
- IDLE with start=1: latch all input vectors and z1/z2 into working registers, clear k and the two accumulators, go to ERR.
- ERR: e = sat16(out_k − x_k). The subtraction uses a 17-bit signed difference, and e is registered. Go to GRAD.
- GRAD: compute four 32-bit signed products: p1 = e·z1, p2 = e·z2, q1 = e·wk1(old), q2 = e·wk2(old).
  - wk1 ← sat16(wk1 − ((p1 >>> 8) >>> LR_SHIFT))
  - wk2 ← sat16(wk2 − ((p2 >>> 8) >>> LR_SHIFT))
  - b3k ← sat16(b3k − (e >>> LR_SHIFT))
  - acc1 += q1; acc2 += q2. Accumulators are 36-bit signed.
  - If k = 8, go to FIN; otherwise k++ and go to ERR.
- FIN: copy the working weights and biases to w_new_vec and b_new_vec. dz1 = sat16(acc1 >>> 8), dz2 = sat16(acc2 >>> 8). Pulse done and go to IDLE.
- Arithmetic rules:
  - All shifts are arithmetic and truncate toward −∞.
  - sat16 clamps to the range 0x8000..0x7FFF.
  - Intermediates are wide enough that only sat16 can clip.
- Outputs hold the last completed result until the next FIN. A new run never exposes partial values.
- start is ignored in ERR, GRAD and FIN; there is no queuing.
- Unused LR_SHIFT values above 15 are illegal. There is no runtime check.

## Timing
- Reset (asynchronous, any state): state = IDLE, k = 0, accumulators = 0, w_new_vec = 0, b_new_vec = 0, dz1 = dz2 = 0, busy = 0, done = 0.
- Reset mid-run: the run is aborted, outputs are cleared, and there is no done pulse.
- start is sampled at edge T0. busy = 1 from T0.
- Element k: e is registered at edge T0+2k+1; weights and accumulators update at edge T0+2k+2.
- At edge T0+18 the state is FIN. At edge T0+19 the outputs update, done = 1 for that one cycle, busy = 0, and the state is IDLE.
- Total latency: start to done = 19 cycles.
- Back-to-back: start may be asserted in the cycle done is high; it is sampled at the next edge (IDLE).
- Inputs need only be valid at the start edge, because everything is latched.

## Test plan
- Zero error: out_vec = x_vec (all 0x0100), any weights and biases → after 19 cycles, w_new_vec = w_vec, b_new_vec = b_vec, dz1 = dz2 = 0, with exactly one done pulse.
- Single error, LR_SHIFT = 4:
  - Stimulus: out1 = 0x0180, x1 = 0x0100, other outputs equal to their targets, z1 = 0x0100, z2 = 0, w11 = 0x0024, w12 = 0x0044, b31 = 0x04F0.
  - Required: w11 → 0x001C, w12 → 0x0044, b31 → 0x04E8, dz1 = 0x0012, dz2 = 0x0022, all other elements unchanged.
- Saturation: out1 = 0x8000, x1 = 0x7FFF (so e saturates to 0x8000), z1 = 0x7FFF, w11 = 0x7FF0 → w11 = 0x7FFF. Also check that b31 = 0x7FF8 increases by 0x0800 and saturates when starting ≥ 0x7800.
- Latency and handshake: busy rises at the start edge, done is high exactly at T0+19 for one cycle, and a second start pulse at T0+5 is ignored (no second done and no output change).
- Reset mid-run: assert rst at T0+7 → all outputs read 0 immediately (asynchronously). After release, a fresh start gives correct results with 19-cycle latency.
- Back-to-back: start is asserted again during the done cycle with new vectors → the second done arrives 19 cycles later, and the first result holds until then.
